// File: rtl/cache_controller_if.sv
// cache_controller_if
// Bundles the three buses a cache controller sits between:
//   CPU side   : cpu_req, cpu_we, cpu_is_word, cpu_addr, cpu_wdata -> controller;
//                cpu_rdata, stall -> CPU
//   Cache side : cache_hit, cache_dirty, cache_dout, cache_wb_addr -> controller;
//                cache_addr, cache_din, we_cache, set_valid, set_dirty, is_word -> cache
//   Memory side: mem_rdata, mem_ready -> controller;
//                mem_addr, mem_wdata, mem_re, mem_we -> memory
// modport master : the environment (CPU, cache array, memory) around the controller
// modport slave  : the controller itself
interface cache_controller_if;
    logic        cpu_req;
    logic        cpu_we;
    logic        cpu_is_word;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        stall;

    logic        cache_hit;
    logic        cache_dirty;
    logic [31:0] cache_dout;
    logic [31:0] cache_wb_addr;
    logic [31:0] cache_addr;
    logic [31:0] cache_din;
    logic        we_cache;
    logic        set_valid;
    logic        set_dirty;
    logic        is_word;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_re;
    logic        mem_we;
    logic        mem_ready;

    modport master (
        output cpu_req, cpu_we, cpu_is_word, cpu_addr, cpu_wdata,
        input  cpu_rdata, stall,
        output cache_hit, cache_dirty, cache_dout, cache_wb_addr,
        input  cache_addr, cache_din, we_cache, set_valid, set_dirty, is_word,
        input  mem_addr, mem_wdata, mem_re, mem_we,
        output mem_rdata, mem_ready
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_is_word, cpu_addr, cpu_wdata,
        output cpu_rdata, stall,
        input  cache_hit, cache_dirty, cache_dout, cache_wb_addr,
        output cache_addr, cache_din, we_cache, set_valid, set_dirty, is_word,
        output mem_addr, mem_wdata, mem_re, mem_we,
        input  mem_rdata, mem_ready
    );
endinterface

// File: rtl/cache_controller.sv
// cache_controller
// Write-back, write-allocate controller for a direct-mapped cache whose lines
// are one 32-bit word. Hits are served combinationally in IDLE; a miss walks
// IDLE -> (WRITEBACK if the victim is dirty) -> REFILL -> IDLE, after which the
// held CPU request is retried and hits.
// Ports:
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset (cache contents untouched)
//   bus        cache_controller_if.slave (CPU, cache and memory signals)
//   hit_count, miss_count, wb_count
//              32-bit saturating event counters, present only when the
//              macro CACHE_CTRL_STATS_EN is defined
module cache_controller (
    input  logic                  clk,
    input  logic                  rst_n,
    cache_controller_if.slave     bus
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count,
    output logic [31:0]           wb_count
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        REFILL
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] req_addr;
    logic        idle_hit;
    logic        idle_miss;

    assign idle_hit  = (state == IDLE) && bus.cpu_req && bus.cache_hit;
    assign idle_miss = (state == IDLE) && bus.cpu_req && !bus.cache_hit;

    // State register and the latched miss address used for cache/memory
    // addressing while the controller is away from IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            req_addr <= 32'h0;
        end else begin
            state <= state_next;
            if (idle_miss) begin
                req_addr <= bus.cpu_addr;
            end
        end
    end

    // Next state and all bus outputs. By default the cache's valid/dirty
    // bits are written back unchanged for a hit or dirty line, so dirty data
    // is never dropped; clean lines that do not match may lose their valid bit.
    // Byte width follows the CPU only in IDLE; write-back and refill always
    // move whole words. Holding rst_n low forces the handshake outputs off
    // combinationally so an in-flight transaction is abandoned at once.
    always_comb begin
        state_next     = state;
        bus.cpu_rdata  = bus.cache_dout;
        bus.stall      = rst_n && bus.cpu_req &&
                         !((state == IDLE) && bus.cache_hit);
        bus.cache_addr = (state == IDLE) ? bus.cpu_addr : req_addr;
        bus.cache_din  = bus.cpu_wdata;
        bus.we_cache   = 1'b0;
        bus.set_valid  = bus.cache_hit | bus.cache_dirty;
        bus.set_dirty  = bus.cache_dirty;
        bus.is_word    = 1'b1;
        bus.mem_addr   = {req_addr[31:2], 2'b00};
        bus.mem_wdata  = bus.cache_dout;
        bus.mem_re     = 1'b0;
        bus.mem_we     = 1'b0;

        case (state)
            IDLE: begin
                bus.is_word = bus.cpu_is_word;
                if (bus.cpu_req) begin
                    if (bus.cache_hit) begin
                        if (bus.cpu_we) begin
                            bus.we_cache  = 1'b1;
                            bus.set_valid = 1'b1;
                            bus.set_dirty = 1'b1;
                        end
                    end else if (bus.cache_dirty) begin
                        state_next = WRITEBACK;
                    end else begin
                        state_next = REFILL;
                    end
                end
            end
            WRITEBACK: begin
                bus.mem_we   = 1'b1;
                bus.mem_addr = bus.cache_wb_addr;
                if (bus.mem_ready) begin
                    state_next = REFILL;
                end
            end
            REFILL: begin
                bus.mem_re = 1'b1;
                if (bus.mem_ready) begin
                    bus.we_cache  = 1'b1;
                    bus.is_word   = 1'b1;
                    bus.cache_din = bus.mem_rdata;
                    bus.set_valid = 1'b1;
                    bus.set_dirty = 1'b0;
                    state_next    = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (!rst_n) begin
            bus.mem_re   = 1'b0;
            bus.mem_we   = 1'b0;
            bus.we_cache = 1'b0;
            state_next   = IDLE;
        end
    end

`ifdef CACHE_CTRL_STATS_EN
    // Saturating event counters: a hit is any IDLE cycle serving a request
    // (including the retry after a refill), a miss is counted when leaving
    // IDLE, and a write-back when memory accepts the victim word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= 32'h0;
            miss_count <= 32'h0;
            wb_count   <= 32'h0;
        end else begin
            if (idle_hit && (hit_count != 32'hFFFF_FFFF)) begin
                hit_count <= hit_count + 32'h1;
            end
            if (idle_miss && (miss_count != 32'hFFFF_FFFF)) begin
                miss_count <= miss_count + 32'h1;
            end
            if ((state == WRITEBACK) && bus.mem_ready &&
                (wb_count != 32'hFFFF_FFFF)) begin
                wb_count <= wb_count + 32'h1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller
// Directed bench for cache_controller. Surrounds the controller with a small
// direct-mapped cache model (16 one-word lines, byte lanes selected by
// address) and a word memory that answers after a fixed number of wait cycles.
// Counter outputs are checked when CACHE_CTRL_STATS_EN is defined.
module tb_cache_controller;

    localparam int MEM_LAT = 3;
    localparam int BOUND   = 60;

    logic clk;
    logic rst_n;

    cache_controller_if bus ();

`ifdef CACHE_CTRL_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
    logic [31:0] wb_count;
`endif

    cache_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave)
`ifdef CACHE_CTRL_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .wb_count   (wb_count)
`endif
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cache array model: valid/dirty are rewritten every cycle from the
    // controller, data and tag only when we_cache is high.
    logic [31:0] c_data  [16];
    logic [25:0] c_tag   [16];
    logic        c_valid [16];
    logic        c_dirty [16];
    logic [3:0]  c_idx;
    logic [31:0] c_word;
    logic [7:0]  c_lane;

    always_comb begin
        c_idx             = bus.cache_addr[5:2];
        c_word            = c_data[c_idx];
        c_lane            = c_word[8*bus.cache_addr[1:0] +: 8];
        bus.cache_hit     = c_valid[c_idx] && (c_tag[c_idx] == bus.cache_addr[31:6]);
        bus.cache_dirty   = c_dirty[c_idx];
        bus.cache_dout    = bus.is_word ? c_word : {24'h0, c_lane};
        bus.cache_wb_addr = {c_tag[c_idx], c_idx, 2'b00};
    end

    always @(posedge clk) begin
        c_valid[c_idx] <= bus.set_valid;
        c_dirty[c_idx] <= bus.set_dirty;
        if (bus.we_cache) begin
            c_tag[c_idx] <= bus.cache_addr[31:6];
            if (bus.is_word) begin
                c_data[c_idx] <= bus.cache_din;
            end else begin
                c_data[c_idx][8*bus.cache_addr[1:0] +: 8] <= bus.cache_din[7:0];
            end
        end
    end

    // Memory model: ready on the MEM_LAT-th cycle of an access.
    logic [31:0] mem [16384];
    int          mem_cnt;

    assign bus.mem_ready = (bus.mem_re || bus.mem_we) && (mem_cnt == MEM_LAT - 1);
    assign bus.mem_rdata = mem[bus.mem_addr[15:2]];

    always @(posedge clk) begin
        if ((bus.mem_re || bus.mem_we) && !bus.mem_ready) begin
            mem_cnt <= mem_cnt + 1;
        end else begin
            mem_cnt <= 0;
        end
        if (bus.mem_we && bus.mem_ready) begin
            mem[bus.mem_addr[15:2]] <= bus.mem_wdata;
        end
    end

    // Observers for memory traffic.
    logic [31:0] rf_addr_seen;
    logic [31:0] wb_addr_seen;
    logic [31:0] wb_data_seen;
    logic        overlap_seen;
    logic        re_seen;

    always @(posedge clk) begin
        if (bus.mem_re && bus.mem_ready) rf_addr_seen <= bus.mem_addr;
        if (bus.mem_we && bus.mem_ready) begin
            wb_addr_seen <= bus.mem_addr;
            wb_data_seen <= bus.mem_wdata;
        end
    end

    always @(negedge clk) begin
        if (bus.mem_re && bus.mem_we) overlap_seen = 1'b1;
        if (bus.mem_re) re_seen = 1'b1;
    end

    int checks;
    int errors;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    int          stalls;
    logic [31:0] rdata;
    logic        snap_we_cache;
    logic        snap_is_word;
    logic        snap_set_dirty;

    // Drives one CPU access from just after a rising edge, counts stall
    // cycles at falling edges, snapshots the completing cycle and drops the
    // request after the edge that retires it.
    task automatic applyStimulus(input logic we, input logic word,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        bus.cpu_req     = 1'b1;
        bus.cpu_we      = we;
        bus.cpu_is_word = word;
        bus.cpu_addr    = addr;
        bus.cpu_wdata   = wdata;
        stalls          = 0;
        forever begin
            @(negedge clk);
            if (!bus.stall || stalls >= BOUND) break;
            stalls++;
        end
        rdata          = bus.cpu_rdata;
        snap_we_cache  = bus.we_cache;
        snap_is_word   = bus.is_word;
        snap_set_dirty = bus.set_dirty;
        @(posedge clk);
        #1;
        bus.cpu_req = 1'b0;
        bus.cpu_we  = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        overlap_seen = 1'b0;
        re_seen      = 1'b0;
        mem_cnt      = 0;
        for (int i = 0; i < 16; i++) begin
            c_data[i]  = 32'h0;
            c_tag[i]   = 26'h0;
            c_valid[i] = 1'b0;
            c_dirty[i] = 1'b0;
        end
        for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
        mem[32'h0000_2010 >> 2] = 32'h1234_5678;
        mem[32'h0000_0010 >> 2] = 32'h0BAD_F00D;
        // Line 4 resident: address 0x10, clean, 0xDEADBEEF.
        c_data[4]  = 32'hDEAD_BEEF;
        c_valid[4] = 1'b1;

        bus.cpu_req     = 1'b0;
        bus.cpu_we      = 1'b0;
        bus.cpu_is_word = 1'b1;
        bus.cpu_addr    = 32'h0;
        bus.cpu_wdata   = 32'h0;
        rst_n           = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_stall",    32'(bus.stall),    32'h0);
        checkOutput("reset_mem_re",   32'(bus.mem_re),   32'h0);
        checkOutput("reset_mem_we",   32'(bus.mem_we),   32'h0);
        checkOutput("reset_we_cache", 32'(bus.we_cache), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Load hit on a resident clean line.
        re_seen = 1'b0;
        applyStimulus(1'b0, 1'b1, 32'h0000_0010, 32'h0);
        checkOutput("hit_rdata",  rdata,          32'hDEAD_BEEF);
        checkOutput("hit_stalls", 32'(stalls),    32'd0);
        checkOutput("hit_no_re",  32'(re_seen),   32'h0);

        // Clean load miss: 1 + 3 stall cycles.
        applyStimulus(1'b0, 1'b1, 32'h0000_2010, 32'h0);
        checkOutput("clean_miss_rdata",  rdata,        32'h1234_5678);
        checkOutput("clean_miss_stalls", 32'(stalls),  32'd4);
        checkOutput("clean_miss_addr",   rf_addr_seen, 32'h0000_2010);

        // Bring 0x10 back (clean miss), then dirty it with a word store.
        applyStimulus(1'b0, 1'b1, 32'h0000_0010, 32'h0);
        checkOutput("reload_rdata",  rdata,       32'h0BAD_F00D);
        checkOutput("reload_stalls", 32'(stalls), 32'd4);
        applyStimulus(1'b1, 1'b1, 32'h0000_0010, 32'hAAAA_0000);
        checkOutput("store_stalls",   32'(stalls),        32'd0);
        checkOutput("store_we_cache", 32'(snap_we_cache), 32'h1);

        // Dirty miss: write back 0xAAAA0000 to 0x10, then refill 0x2010.
        overlap_seen = 1'b0;
        applyStimulus(1'b0, 1'b1, 32'h0000_2010, 32'h0);
        checkOutput("dirty_miss_rdata",  rdata,              32'h1234_5678);
        checkOutput("dirty_miss_stalls", 32'(stalls),        32'd7);
        checkOutput("wb_addr",           wb_addr_seen,       32'h0000_0010);
        checkOutput("wb_data",           wb_data_seen,       32'hAAAA_0000);
        checkOutput("re_we_overlap",     32'(overlap_seen),  32'h0);

        // The written-back word comes back from memory.
        applyStimulus(1'b0, 1'b1, 32'h0000_0010, 32'h0);
        checkOutput("wb_reload_rdata", rdata, 32'hAAAA_0000);

        // Byte store hit into lane 3, then byte and word loads.
        applyStimulus(1'b1, 1'b0, 32'h0000_0013, 32'h0000_005A);
        checkOutput("bstore_stalls",    32'(stalls),         32'd0);
        checkOutput("bstore_we_cache",  32'(snap_we_cache),  32'h1);
        checkOutput("bstore_is_word",   32'(snap_is_word),   32'h0);
        checkOutput("bstore_set_dirty", 32'(snap_set_dirty), 32'h1);
        applyStimulus(1'b0, 1'b0, 32'h0000_0013, 32'h0);
        checkOutput("bload_rdata", rdata, 32'h0000_005A);
        applyStimulus(1'b0, 1'b1, 32'h0000_0010, 32'h0);
        checkOutput("wload_rdata", rdata, 32'h5AAA_0000);

`ifdef CACHE_CTRL_STATS_EN
        checkOutput("hit_count",  hit_count,  32'd9);
        checkOutput("miss_count", miss_count, 32'd4);
        checkOutput("wb_count",   wb_count,   32'd1);
`endif

        // Reset asserted in the middle of a refill.
        bus.cpu_req     = 1'b1;
        bus.cpu_we      = 1'b0;
        bus.cpu_is_word = 1'b1;
        bus.cpu_addr    = 32'h0000_3020;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("refill_mem_re", 32'(bus.mem_re), 32'h1);
        #1;
        bus.cpu_addr = 32'h0000_0040;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mem_re",     32'(bus.mem_re),   32'h0);
        checkOutput("rst_mem_we",     32'(bus.mem_we),   32'h0);
        checkOutput("rst_stall",      32'(bus.stall),    32'h0);
        checkOutput("rst_we_cache",   32'(bus.we_cache), 32'h0);
        checkOutput("rst_cache_addr", bus.cache_addr,    32'h0000_0040);
`ifdef CACHE_CTRL_STATS_EN
        checkOutput("rst_hit_count",  hit_count,  32'h0);
        checkOutput("rst_miss_count", miss_count, 32'h0);
        checkOutput("rst_wb_count",   wb_count,   32'h0);
`endif
        @(posedge clk);
        #1;
        bus.cpu_req = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Cache contents survive reset.
        applyStimulus(1'b0, 1'b1, 32'h0000_0010, 32'h0);
        checkOutput("post_rst_rdata",  rdata,       32'h5AAA_0000);
        checkOutput("post_rst_stalls", 32'(stalls), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
